pipe_stage_hs: RTL and testbench

//  Parametrised inter-stage pipeline register (ID/EX, EX/MEM, ...) for the RISC-V SoC core.

---
 rtl/pipe_stage_hs_pkg.sv | 17 +
 rtl/pipe_stage_hs_if.sv | 17 +
 rtl/pipe_stage_hs_slot.sv | 68 ++++++
 rtl/pipe_stage_hs.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_hs.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked inter-stage pipeline register.
//  - default field widths for a stage instance
//  - occupancy state encoding of the stage FSM
package pipe_stage_hs_pkg;

    localparam int unsigned DefCtrlW = 16;
    localparam int unsigned DefDataW = 202;
    localparam int unsigned DefCntW  = 32;

    // Occupancy: main slot empty / main full / main and skid full.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready pipeline link carrying one control and one data field group.
//  valid  producer -> consumer  entry is live
//  ready  consumer -> producer  consumer takes the entry this cycle
//  ctrl   producer -> consumer  control fields (CTRL_W)
//  data   producer -> consumer  data fields (DATA_W)
interface pipe_stage_hs_if #(
    parameter int unsigned CTRL_W = pipe_stage_hs_pkg::DefCtrlW,
    parameter int unsigned DATA_W = pipe_stage_hs_pkg::DefDataW
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_hs_slot.sv
// One pipeline entry: valid flag plus control and data fields.
//  clk, rst          rising-edge clock, synchronous active-high reset
//  load_i            capture ctrl_i/data_i and mark valid
//  unload_i          mark empty (control zeroed, data kept)
//  flush_i           mark empty, control zeroed, data zeroed when CLEAR_DATA
//  ctrl_i, data_i    entry to capture
//  valid_o, ctrl_o, data_o  stored entry; ctrl_o is zero whenever valid_o is 0
module pipe_stage_hs_slot
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned CTRL_W     = DefCtrlW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              flush_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (unload_i) begin
            // Empty slot carries zero control so it reads as a bubble.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked inter-stage pipeline register with optional skid slot and stall counter.
//  clk, rst    rising-edge clock, synchronous active-high reset
//  in_if       upstream link (slave): valid/ctrl/data in, ready out
//  out_if      downstream link (master): valid/ctrl/data out, ready in
//  flush       drop all held entries and any entry offered this cycle
//  stall_cnt   saturating count of cycles with out valid and not ready
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned CTRL_W     = DefCtrlW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter bit          SKID       = 1'b1,
    parameter bit          CLEAR_DATA = 1'b0,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_hs_if.slave   in_if,
    pipe_stage_hs_if.master  out_if,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e            state_q, state_d;
    logic              in_fire, out_fire;
    logic              main_load, main_unload, main_from_skid;
    logic              skid_load, skid_unload;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign in_fire  = in_if.valid & in_if.ready;
    assign out_fire = main_valid & out_if.ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_unload    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        if (flush) begin
            // Slots see flush directly; only the occupancy needs resetting here.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        // Only reachable with a skid slot: single-entry ready forbids it.
                        skid_load = 1'b1;
                        state_d   = StTwo;
                    end else if (out_fire) begin
                        main_unload = 1'b1;
                        state_d     = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_unload    = 1'b1;
                        state_d        = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_if.ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_if.data;

    pipe_stage_hs_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load_i   (main_load),
        .unload_i (main_unload),
        .flush_i  (flush),
        .ctrl_i   (main_ctrl_in),
        .data_i   (main_data_in),
        .valid_o  (main_valid),
        .ctrl_o   (main_ctrl),
        .data_o   (main_data)
    );

    if (SKID) begin : g_skid
        logic in_ready_q;
        logic skid_valid_unused;

        // Ready is a flop of next occupancy, so out_if.ready never reaches in_if.ready.
        always_ff @(posedge clk) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != StTwo);
            end
        end

        pipe_stage_hs_slot #(
            .CTRL_W     (CTRL_W),
            .DATA_W     (DATA_W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .load_i   (skid_load),
            .unload_i (skid_unload),
            .flush_i  (flush),
            .ctrl_i   (in_if.ctrl),
            .data_i   (in_if.data),
            .valid_o  (skid_valid_unused),
            .ctrl_o   (skid_ctrl),
            .data_o   (skid_data)
        );

        assign in_if.ready = in_ready_q;
    end else begin : g_no_skid
        assign skid_ctrl   = '0;
        assign skid_data   = '0;
        assign in_if.ready = ~main_valid | out_if.ready;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_if.valid = main_valid;
    assign out_if.ctrl  = main_ctrl;
    assign out_if.data  = main_data;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances.
//  dut_a  SKID=1, CLEAR_DATA=0, 32-bit counter (scoreboarded)
//  dut_b  same stimulus as dut_a, 4-bit counter (saturation)
//  dut_c  SKID=0, CLEAR_DATA=1 (scoreboarded)
module tb_pipe_stage_hs;

    localparam int unsigned CW = 16;
    localparam int unsigned DW = 202;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic clk;
    logic rst;
    logic flush;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [31:0] c_cnt;

    int checks   = 0;
    int failures = 0;

    ent_t q_a[$];
    ent_t q_c[$];

    pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) a_in ();
    pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) a_out ();
    pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) b_in ();
    pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) b_out ();
    pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) c_in ();
    pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) c_out ();

    assign b_in.valid  = a_in.valid;
    assign b_in.ctrl   = a_in.ctrl;
    assign b_in.data   = a_in.data;
    assign b_out.ready = a_out.ready;

    pipe_stage_hs #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLEAR_DATA(1'b0), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst(rst), .in_if(a_in), .out_if(a_out), .flush(flush), .stall_cnt(a_cnt)
    );

    pipe_stage_hs #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLEAR_DATA(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .in_if(b_in), .out_if(b_out), .flush(flush), .stall_cnt(b_cnt)
    );

    pipe_stage_hs #(
        .CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CLEAR_DATA(1'b1), .CNT_W(32)
    ) dut_c (
        .clk(clk), .rst(rst), .in_if(c_in), .out_if(c_out), .flush(flush), .stall_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor handshakes at the falling edge, then return 1 time unit after
    // the next rising edge so registered outputs have settled.
    task automatic cycle();
        ent_t e;
        logic a_if, a_of, c_if, c_of;
        @(negedge clk);
        a_if = a_in.valid & a_in.ready;
        a_of = a_out.valid & a_out.ready;
        c_if = c_in.valid & c_in.ready;
        c_of = c_out.valid & c_out.ready;
        if (!a_out.valid) chk("a_bubble_ctrl", a_out.ctrl, '0);
        if (!c_out.valid) chk("c_bubble_ctrl", c_out.ctrl, '0);
        if (rst) begin
            q_a.delete();
            q_c.delete();
        end else begin
            if (a_of) begin
                chk("a_sb_underflow", q_a.size() != 0, 1'b1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("a_out_ctrl", a_out.ctrl, e.ctrl);
                    chk("a_out_data", a_out.data, e.data);
                end
            end
            if (c_of) begin
                chk("c_sb_underflow", q_c.size() != 0, 1'b1);
                if (q_c.size() != 0) begin
                    e = q_c.pop_front();
                    chk("c_out_ctrl", c_out.ctrl, e.ctrl);
                    chk("c_out_data", c_out.data, e.data);
                end
            end
            if (a_if && !flush) begin
                e.ctrl = a_in.ctrl;
                e.data = a_in.data;
                q_a.push_back(e);
            end
            if (c_if && !flush) begin
                e.ctrl = c_in.ctrl;
                e.data = c_in.data;
                q_c.push_back(e);
            end
            if (flush) begin
                q_a.delete();
                q_c.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                           input logic rdy);
        a_in.valid  = v;
        a_in.ctrl   = c;
        a_in.data   = d;
        a_out.ready = rdy;
    endtask

    task automatic drive_c(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                           input logic rdy);
        c_in.valid  = v;
        c_in.ctrl   = c;
        c_in.data   = d;
        c_out.ready = rdy;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive_a(1'b0, '0, '0, 1'b1);
        drive_c(1'b0, '0, '0, 1'b1);

        // Reset for two cycles, then check the idle state.
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_a_valid", a_out.valid, 1'b0);
        chk("rst_a_ctrl", a_out.ctrl, '0);
        chk("rst_a_data", a_out.data, '0);
        chk("rst_a_cnt", a_cnt, '0);
        chk("rst_a_ready", a_in.ready, 1'b1);
        chk("rst_b_valid", b_out.valid, 1'b0);
        chk("rst_c_valid", c_out.valid, 1'b0);
        chk("rst_c_ready", c_in.ready, 1'b1);

        // Streaming with downstream always ready: one-cycle latency, ready stays high.
        for (int k = 0; k < 8; k++) begin
            drive_a(1'b1, CW'(k), DW'(k * 3), 1'b1);
            chk("stream_in_ready", a_in.ready, 1'b1);
            cycle();
            chk("stream_valid", a_out.valid, 1'b1);
            chk("stream_ctrl", a_out.ctrl, CW'(k));
            chk("stream_data", a_out.data, DW'(k * 3));
        end
        drive_a(1'b0, '0, '0, 1'b1);
        cycle();
        chk("stream_drained", a_out.valid, 1'b0);
        chk("stream_sb_empty", q_a.size(), 0);
        chk("stream_no_stall", a_cnt, '0);

        // Back-pressure: two entries accepted, then ready drops and the head holds.
        for (int j = 0; j < 4; j++) begin
            drive_a(1'b1, CW'(16'h100 + j), DW'(32'h5000 + j), 1'b0);
            cycle();
        end
        chk("skid_in_ready_low", a_in.ready, 1'b0);
        chk("skid_hold_ctrl", a_out.ctrl, CW'(16'h100));
        chk("skid_hold_data", a_out.data, DW'(32'h5000));
        chk("skid_sb_two", q_a.size(), 2);
        chk("skid_stall_cnt", a_cnt, 32'd3);
        drive_a(1'b0, '0, '0, 1'b1);
        cycle();
        chk("skid_release_ctrl", a_out.ctrl, CW'(16'h101));
        chk("skid_release_ready", a_in.ready, 1'b1);
        cycle();
        chk("skid_drained", a_out.valid, 1'b0);
        chk("skid_sb_empty", q_a.size(), 0);
        chk("skid_stall_final", a_cnt, 32'd3);

        // Flush while both slots are full with an entry offered.
        drive_a(1'b1, CW'(16'h200), DW'(32'h9000), 1'b0);
        cycle();
        drive_a(1'b1, CW'(16'h201), DW'(32'h9001), 1'b0);
        cycle();
        chk("flush2_pre_ready", a_in.ready, 1'b0);
        flush = 1'b1;
        drive_a(1'b1, CW'(16'h2aa), DW'(32'h77), 1'b0);
        cycle();
        flush = 1'b0;
        chk("flush2_valid", a_out.valid, 1'b0);
        chk("flush2_ctrl", a_out.ctrl, '0);
        chk("flush2_data_kept", a_out.data, DW'(32'h9000));
        chk("flush2_ready", a_in.ready, 1'b1);
        drive_a(1'b0, '0, '0, 1'b1);
        cycle();
        chk("flush2_input_dropped", a_out.valid, 1'b0);
        chk("flush2_stall_kept", a_cnt, 32'd5);

        // Flush with one entry held while ready is high: the offered entry is dropped.
        drive_a(1'b1, CW'(16'h3), DW'(32'h3), 1'b0);
        cycle();
        flush = 1'b1;
        drive_a(1'b1, CW'(16'h4), DW'(32'h4), 1'b0);
        chk("flush1_ready", a_in.ready, 1'b1);
        cycle();
        flush = 1'b0;
        drive_a(1'b0, '0, '0, 1'b1);
        chk("flush1_valid", a_out.valid, 1'b0);
        cycle();
        chk("flush1_input_dropped", a_out.valid, 1'b0);
        chk("flush1_stall", a_cnt, 32'd6);

        // Long stall: 4-bit counter saturates, 32-bit counter keeps counting.
        drive_a(1'b1, CW'(16'h33), DW'(32'h33), 1'b0);
        cycle();
        drive_a(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_b_cnt", b_cnt, 4'hf);
        chk("sat_a_cnt", a_cnt, 32'd26);
        chk("sat_hold_ctrl", a_out.ctrl, CW'(16'h33));
        for (int i = 0; i < 3; i++) cycle();
        chk("sat_b_stays", b_cnt, 4'hf);
        chk("sat_a_cnt2", a_cnt, 32'd29);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive_a(1'b0, '0, '0, 1'b1);
        chk("mid_rst_b_cnt", b_cnt, 4'h0);
        chk("mid_rst_a_cnt", a_cnt, '0);
        chk("mid_rst_a_valid", a_out.valid, 1'b0);
        chk("mid_rst_a_ready", a_in.ready, 1'b1);
        cycle();
        chk("mid_rst_no_residue", a_out.valid, 1'b0);

        // Single-entry variant: hold, flush clears data, then replace without a bubble.
        drive_c(1'b1, CW'(16'h55), DW'(32'habc), 1'b0);
        cycle();
        drive_c(1'b0, '0, '0, 1'b0);
        cycle();
        #1;
        chk("c_hold_ctrl", c_out.ctrl, CW'(16'h55));
        chk("c_hold_data", c_out.data, DW'(32'habc));
        chk("c_ready_low", c_in.ready, 1'b0);
        chk("c_stall", c_cnt, 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("c_flush_valid", c_out.valid, 1'b0);
        chk("c_flush_ctrl", c_out.ctrl, '0);
        chk("c_flush_data", c_out.data, '0);
        drive_c(1'b1, CW'(16'h1), DW'(32'h11), 1'b0);
        cycle();
        drive_c(1'b1, CW'(16'h2), DW'(32'h22), 1'b1);
        #1;
        chk("c_comb_ready", c_in.ready, 1'b1);
        cycle();
        chk("c_replace_valid", c_out.valid, 1'b1);
        chk("c_replace_ctrl", c_out.ctrl, CW'(16'h2));
        drive_c(1'b1, CW'(16'h3), DW'(32'h33), 1'b1);
        cycle();
        chk("c_replace2_ctrl", c_out.ctrl, CW'(16'h3));
        chk("c_replace2_data", c_out.data, DW'(32'h33));
        drive_c(1'b0, '0, '0, 1'b1);
        cycle();
        chk("c_drained", c_out.valid, 1'b0);
        chk("c_sb_empty", q_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
